// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the 16-bit 5-stage pipelined CPU.
//
// Owns the PC register, the PC+step incrementer, the PC-source mux and the
// IF/ID pipeline register. A small BOOT/RUN/HALT state machine inserts a
// single bubble after reset and freezes fetch once a halt opcode is captured.
//
// Ports:
//   clk           rising-edge clock
//   reset         synchronous, active-high reset
//   stall         hold PC and IF/ID (hazard unit)
//   flush         squash the instruction being fetched (ID stage)
//   pc_src        1 = next PC comes from branch_target
//   branch_target redirect address; bit 0 is forced to zero
//   imem_rdata    instruction word, combinational from imem_addr
//   imem_addr     instruction-memory address (= pc_out)
//   pc_out        current PC register
//   pc_plus2      pc_out + PC_STEP, modulo 2^16
//   next_pc       PC-source mux output (value PC takes on the next edge)
//   ifid_out      {PC+step of captured instruction, instruction}
//   ifid_valid    1 = ifid_out holds a real instruction
//   halted        1 = fetch is frozen in HALT
//
// Control handshake: stall, flush and pc_src are level signals sampled on
// each rising edge; pc_src and flush both take priority over stall, and all
// three are ignored in BOOT and HALT. Only reset leaves HALT.
module fetch_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_WORD  = 16'h0000,
  parameter logic [15:0] HALT_WORD = 16'hFFFF,
  parameter logic [15:0] PC_STEP   = 16'd2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        pc_src,
  input  logic [15:0] branch_target,
  input  logic [15:0] imem_rdata,
  output logic [15:0] imem_addr,
  output logic [15:0] pc_out,
  output logic [15:0] pc_plus2,
  output logic [15:0] next_pc,
  output logic [31:0] ifid_out,
  output logic        ifid_valid,
  output logic        halted
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [31:0] ifid_q, ifid_d;
  logic        ifid_valid_q, ifid_valid_d;

  logic [15:0] pc_inc;
  logic [15:0] redirect_pc;
  logic        halt_fetch;

  always_comb begin
    // Natural 16-bit wrap: 16'hFFFE + 2 = 16'h0000.
    pc_inc      = pc_q + PC_STEP;
    redirect_pc = {branch_target[15:1], 1'b0};
    // A halt word only counts on a clean, committed fetch; with flush or
    // pc_src it is on the wrong path and the redirect wins.
    halt_fetch  = (state_q == ST_RUN) && (imem_rdata == HALT_WORD) &&
                  !stall && !flush && !pc_src;

    state_d      = state_q;
    pc_d         = pc_q;
    ifid_d       = ifid_q;
    ifid_valid_d = ifid_valid_q;

    case (state_q)
      ST_BOOT: begin
        ifid_d       = {16'h0000, NOP_WORD};
        ifid_valid_d = 1'b0;
        state_d      = ST_RUN;
      end
      ST_RUN: begin
        if (pc_src) begin
          pc_d = redirect_pc;
        end else if (!stall && !halt_fetch) begin
          pc_d = pc_inc;
        end

        if (flush) begin
          ifid_d       = {pc_inc, NOP_WORD};
          ifid_valid_d = 1'b0;
        end else if (!stall) begin
          ifid_d       = {pc_inc, imem_rdata};
          ifid_valid_d = 1'b1;
        end

        if (halt_fetch) begin
          state_d = ST_HALT;
        end
      end
      ST_HALT: begin
        ifid_d       = {pc_inc, NOP_WORD};
        ifid_valid_d = 1'b0;
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_BOOT;
      pc_q         <= RESET_PC;
      ifid_q       <= {16'h0000, NOP_WORD};
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_q       <= ifid_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  assign pc_out     = pc_q;
  assign imem_addr  = pc_q;
  assign pc_plus2   = pc_inc;
  assign next_pc    = pc_d;
  assign ifid_out   = ifid_q;
  assign ifid_valid = ifid_valid_q;
  assign halted     = (state_q == ST_HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: self-checking bench for fetch_stage. A behavioural
// instruction memory answers combinationally; expected IF/ID words are
// pushed to exp_q when a fetch is driven and popped after the edge.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        pc_src;
  logic [15:0] branch_target;
  logic [15:0] imem_rdata;
  logic [15:0] imem_addr;
  logic [15:0] pc_out;
  logic [15:0] pc_plus2;
  logic [15:0] next_pc;
  logic [31:0] ifid_out;
  logic        ifid_valid;
  logic        halted;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_q[$];

  logic        halt_en   = 1'b0;
  logic [15:0] halt_addr = 16'h0010;

  fetch_stage dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .flush         (flush),
    .pc_src        (pc_src),
    .branch_target (branch_target),
    .imem_rdata    (imem_rdata),
    .imem_addr     (imem_addr),
    .pc_out        (pc_out),
    .pc_plus2      (pc_plus2),
    .next_pc       (next_pc),
    .ifid_out      (ifid_out),
    .ifid_valid    (ifid_valid),
    .halted        (halted)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instruction memory ----------------
  function automatic logic [15:0] imem_fn(input logic [15:0] a);
    if (a == 16'h0000) return 16'h1234;
    if (a == 16'h0002) return 16'h5678;
    return {8'h5A, a[7:0]};
  endfunction

  assign imem_rdata = (halt_en && imem_addr == halt_addr) ? 16'hFFFF
                                                          : imem_fn(imem_addr);

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic f, input logic p,
                       input logic [15:0] bt);
    stall         = s;
    flush         = f;
    pc_src        = p;
    branch_target = bt;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 16'h0000);
  endtask

  // Push the expected IF/ID word for a clean fetch at pc, then advance.
  task automatic fetch_and_check(input logic [15:0] pc, input string name);
    logic [31:0] exp;
    idle();
    exp_q.push_back({pc + 16'd2, imem_fn(pc)});
    tick();
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, got ifid=%h", name, ifid_out);
    end else begin
      exp = exp_q.pop_front();
      if (ifid_out !== exp || ifid_valid !== 1'b1) begin
        errors++;
        $display("FAIL %s: ifid=%h valid=%b, expected ifid=%h valid=1",
                 name, ifid_out, ifid_valid, exp);
      end
    end
    checks++;
    if (pc_out !== pc + 16'd2) begin
      errors++;
      $display("FAIL %s_pc: pc=%h, expected %h", name, pc_out, pc + 16'd2);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 16'h00AA);
    tick();
    tick();
    checks++;
    if (pc_out !== 16'h0000 || ifid_out !== 32'h0 || ifid_valid !== 1'b0 ||
        halted !== 1'b0) begin
      errors++;
      $display("FAIL reset: pc=%h ifid=%h valid=%b halted=%b, expected 0/0/0/0",
               pc_out, ifid_out, ifid_valid, halted);
    end
    // BOOT cycle: controls are ignored.
    reset = 1'b0;
    drive(1'b0, 1'b1, 1'b1, 16'h0080);
    tick();
    checks++;
    if (pc_out !== 16'h0000 || ifid_valid !== 1'b0 || ifid_out !== 32'h0) begin
      errors++;
      $display("FAIL boot: pc=%h valid=%b ifid=%h, expected pc=0 valid=0 ifid=0",
               pc_out, ifid_valid, ifid_out);
    end
  endtask

  task automatic test_fetch();
    fetch_and_check(16'h0000, "fetch0");
    fetch_and_check(16'h0002, "fetch2");
  endtask

  task automatic test_stall();
    drive(1'b1, 1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (pc_out !== 16'h0004 || ifid_out !== 32'h0004_5678 || ifid_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall%0d: pc=%h ifid=%h valid=%b, expected 0004/00045678/1",
                 i, pc_out, ifid_out, ifid_valid);
      end
    end
    fetch_and_check(16'h0004, "stall_resume");
  endtask

  task automatic test_branch_flush();
    drive(1'b1, 1'b1, 1'b1, 16'h0041);
    #1;
    checks++;
    if (next_pc !== 16'h0040) begin
      errors++;
      $display("FAIL branch_next_pc: next_pc=%h, expected 0040", next_pc);
    end
    tick();
    checks++;
    if (pc_out !== 16'h0040 || ifid_out !== 32'h0008_0000 || ifid_valid !== 1'b0) begin
      errors++;
      $display("FAIL branch_flush: pc=%h ifid=%h valid=%b, expected 0040/00080000/0",
               pc_out, ifid_out, ifid_valid);
    end
    fetch_and_check(16'h0040, "branch_target_fetch");
  endtask

  task automatic test_wrap();
    drive(1'b0, 1'b1, 1'b1, 16'hFFFF);
    tick();
    checks++;
    if (pc_out !== 16'hFFFE || pc_plus2 !== 16'h0000) begin
      errors++;
      $display("FAIL wrap_setup: pc=%h pc_plus2=%h, expected FFFE/0000",
               pc_out, pc_plus2);
    end
    fetch_and_check(16'hFFFE, "wrap");
    checks++;
    if (ifid_out[31:16] !== 16'h0000) begin
      errors++;
      $display("FAIL wrap_ifid_hi: got %h, expected 0000", ifid_out[31:16]);
    end
  endtask

  task automatic test_halt();
    halt_en = 1'b1;
    drive(1'b0, 1'b1, 1'b1, 16'h0010);
    tick();
    // Halt word on the wrong path: redirect wins, no halt.
    drive(1'b0, 1'b1, 1'b1, 16'h0020);
    tick();
    checks++;
    if (halted !== 1'b0 || pc_out !== 16'h0020 || ifid_out !== 32'h0012_0000 ||
        ifid_valid !== 1'b0) begin
      errors++;
      $display("FAIL halt_wrong_path: halted=%b pc=%h ifid=%h valid=%b, expected 0/0020/00120000/0",
               halted, pc_out, ifid_out, ifid_valid);
    end
    drive(1'b0, 1'b1, 1'b1, 16'h0010);
    tick();
    idle();
    #1;
    checks++;
    if (next_pc !== 16'h0010) begin
      errors++;
      $display("FAIL halt_next_pc: next_pc=%h, expected 0010", next_pc);
    end
    tick();
    checks++;
    if (ifid_out !== 32'h0012_FFFF || ifid_valid !== 1'b1 || halted !== 1'b1 ||
        pc_out !== 16'h0010) begin
      errors++;
      $display("FAIL halt_capture: ifid=%h valid=%b halted=%b pc=%h, expected 0012FFFF/1/1/0010",
               ifid_out, ifid_valid, halted, pc_out);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 16'h0080);
      tick();
      checks++;
      if (ifid_valid !== 1'b0 || halted !== 1'b1 || pc_out !== 16'h0010 ||
          ifid_out !== 32'h0012_0000) begin
        errors++;
        $display("FAIL halt_hold%0d: valid=%b halted=%b pc=%h ifid=%h, expected 0/1/0010/00120000",
                 i, ifid_valid, halted, pc_out, ifid_out);
      end
    end
  endtask

  task automatic test_reset_in_halt();
    reset = 1'b1;
    idle();
    tick();
    checks++;
    if (pc_out !== 16'h0000 || halted !== 1'b0 || ifid_valid !== 1'b0 ||
        ifid_out !== 32'h0) begin
      errors++;
      $display("FAIL reset_halt: pc=%h halted=%b valid=%b ifid=%h, expected 0/0/0/0",
               pc_out, halted, ifid_valid, ifid_out);
    end
    reset   = 1'b0;
    halt_en = 1'b0;
    tick();
    checks++;
    if (pc_out !== 16'h0000 || ifid_valid !== 1'b0) begin
      errors++;
      $display("FAIL reboot: pc=%h valid=%b, expected 0000/0", pc_out, ifid_valid);
    end
    fetch_and_check(16'h0000, "refetch0");
  endtask

  // Random stall/flush stream from pc=2 against a simple reference model.
  task automatic test_back_to_back();
    logic [15:0] exp_pc;
    logic [31:0] exp_ifid;
    logic        exp_valid;
    logic        s, f;
    exp_pc    = 16'h0002;
    exp_ifid  = 32'h0002_1234;
    exp_valid = 1'b1;
    for (int i = 0; i < 24; i++) begin
      s = 1'($urandom_range(0, 2) == 0);
      f = 1'($urandom_range(0, 4) == 0);
      drive(s, f, 1'b0, 16'h0000);
      if (f) begin
        exp_ifid  = {exp_pc + 16'd2, 16'h0000};
        exp_valid = 1'b0;
      end else if (!s) begin
        exp_ifid  = {exp_pc + 16'd2, imem_fn(exp_pc)};
        exp_valid = 1'b1;
      end
      exp_q.push_back(exp_ifid);
      if (!s) exp_pc = exp_pc + 16'd2;
      tick();
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL b2b%0d: scoreboard empty", i);
      end else if (ifid_out !== exp_q.pop_front() || ifid_valid !== exp_valid ||
                   pc_out !== exp_pc) begin
        errors++;
        $display("FAIL b2b%0d: ifid=%h valid=%b pc=%h, expected ifid=%h valid=%b pc=%h",
                 i, ifid_out, ifid_valid, pc_out, exp_ifid, exp_valid, exp_pc);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_fetch();
    test_stall();
    test_branch_flush();
    test_wrap();
    test_halt();
    test_reset_in_halt();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
